uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning sysclk cycles per line bit, legal range 1..65535.
REQ-003 The block SHALL have parameter PARITY, default 0, meaning 0=none, 1=odd, 2=even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, 1 or 2.
REQ-005 The block SHALL have port sysclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port TX_DATA, input, DATA_BITS wide: payload, sampled only on the accepting edge.
REQ-008 The block SHALL have port TX_EN, input, 1 bit: send request.
REQ-009 The block SHALL have port TX_STATUS, output, 1 bit: 1=idle/ready, 0=frame in progress.
REQ-010 The block SHALL have port TX_DONE, output, 1 bit: one-cycle pulse at frame end.
REQ-011 The block SHALL have port UART_TX, output, 1 bit: serial line, idle high, registered.

Function
REQ-012 States SHALL be IDLE, START, DATA, PAR, STOP.
REQ-013 Accept SHALL occur on a rising edge with TX_EN=1 and TX_STATUS=1: TX_DATA latched into shift register, state to START, TX_STATUS to 0.
REQ-014 TX_EN while TX_STATUS=0 SHALL be ignored; latched data SHALL NOT change mid-frame.
REQ-015 UART_TX SHALL go 0 on the accepting edge (start bit); latency TX_EN-sampled to line-low = 0 cycles after that edge.
REQ-016 Each bit SHALL hold exactly CLKS_PER_BIT cycles, timed by a bit counter counting 0..CLKS_PER_BIT-1, reset to 0 on every state/bit change.
REQ-017 DATA SHALL send DATA_BITS bits LSB first; a bit index counter 0..DATA_BITS-1 selects the bit.
REQ-018 After the last data bit: PARITY!=0 goes to PAR, else STOP.
REQ-019 PAR bit SHALL be XOR of the latched bits for even, and its inverse for odd (total ones count odd including parity).
REQ-020 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 On the edge ending the final stop cycle: state IDLE, TX_STATUS=1, TX_DONE=1 for exactly that one cycle.
REQ-022 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles from accept to TX_STATUS=1.
REQ-023 TX_EN=1 in the cycle TX_STATUS returns 1 SHALL be accepted on the next edge; back-to-back frames SHALL have no extra idle bit beyond the stop bits plus one cycle.
REQ-024 CLKS_PER_BIT=1 SHALL work: one cycle per bit.
REQ-025 Illegal parameters SHALL be rejected at elaboration.

Reset
REQ-026 While reset=1: state IDLE, UART_TX=1, TX_STATUS=1, TX_DONE=0, counters 0, shift register 0.
REQ-027 Reset asserted mid-frame SHALL abort immediately (asynchronously) with UART_TX=1; no TX_DONE SHALL be produced for the aborted frame.
REQ-028 The first accept SHALL be possible on the first edge after reset deasserts.

Structure
REQ-029 Package uart_pkg SHALL hold the state enumeration and the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), shared with the future receiver.
REQ-030 The bit-period timer SHALL be sub-module uart_baud_tick (CLKS_PER_BIT parameter, clear input, tick output); all other logic SHALL be in uart_tx_param.

Verification
REQ-031 DATA_BITS=8, CLKS_PER_BIT=4, no parity, 1 stop, TX_DATA=0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each 4 cycles; TX_DONE at cycle 40; TX_STATUS low for 40 cycles.
REQ-032 PARITY=2 (even), 0x07 -> parity bit 1; PARITY=1 (odd), 0x07 -> parity bit 0; frame 11 bits.
REQ-033 DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=1, 0x7F -> 0,1×7,1,1; TX_DONE at cycle 10.
REQ-034 TX_EN pulsed again at cycle 5 of a frame with different data -> ignored; the first frame completes unchanged, and no second frame is sent.
REQ-035 TX_EN held high continuously for data 0x55 then 0xAA -> two frames back-to-back with exactly one-cycle idle gap after the stop bit(s).
REQ-036 Reset asserted during the DATA state -> UART_TX=1 and TX_STATUS=1 in the same cycle; no TX_DONE; a fresh frame is sent correctly after release.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: frame state encoding and parity modes.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Counter width for a modulo-n counter; never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the
// last count. clear holds the count at zero.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap on the last cycle of a bit, hold at zero on clear.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, LSB-first data, optional
// parity, 1 or 2 stop bits, with a registered serial line.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_EN,
    output logic                 TX_STATUS,
    output logic                 TX_DONE,
    output logic                 UART_TX
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be 1..65535");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN)
    begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [3:0]           idx_q, idx_d;
    logic                 line_q, line_d;
    logic                 status_q, status_d;
    logic                 done_q, done_d;

    logic                 tick;
    logic                 par_bit;
    logic [3:0]           nxt_idx;
    logic [DATA_BITS-1:0] data_sh;

    // The timer only runs while a frame is in flight.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .sysclk(sysclk),
        .reset (reset),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    assign nxt_idx   = idx_q + 4'd1;
    assign data_sh   = data_q >> nxt_idx;
    assign par_bit   = (PARITY == PAR_ODD) ? ~(^data_q) : (^data_q);

    assign TX_STATUS = status_q;
    assign TX_DONE   = done_q;
    assign UART_TX   = line_q;

    // Frame sequencing; the line value for the next bit is chosen here
    // so the registered output changes on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        line_d   = line_q;
        status_d = status_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (TX_EN) begin
                    data_d   = TX_DATA;
                    state_d  = START;
                    idx_d    = '0;
                    line_d   = 1'b0;
                    status_d = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    line_d  = data_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = PAR;
                            line_d  = par_bit;
                        end else begin
                            state_d = STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        idx_d  = nxt_idx;
                        line_d = data_sh[0];
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                    line_d  = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (idx_q == LAST_STOP) begin
                        state_d  = IDLE;
                        idx_d    = '0;
                        status_d = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        idx_d = nxt_idx;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                idx_d    = '0;
                line_d   = 1'b1;
                status_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame at once.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            idx_q    <= '0;
            line_q   <= 1'b1;
            status_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            line_q   <= line_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations, each frame compared
// cycle by cycle against a bit list built from the frame rules.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int NI = 5;
    localparam int DB [NI] = '{8, 8, 8, 7, 9};
    localparam int CB [NI] = '{4, 4, 4, 1, 3};
    localparam int PB [NI] = '{0, 2, 1, 0, 1};
    localparam int SB [NI] = '{1, 1, 1, 2, 2};

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       rst [NI];
    logic       en  [NI];
    logic [8:0] dat [NI];
    logic       ln  [NI];
    logic       st  [NI];
    logic       dn  [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(DB[0]), .CLKS_PER_BIT(CB[0]),
                    .PARITY(PB[0]), .STOP_BITS(SB[0])) u0 (
        .sysclk(clk), .reset(rst[0]), .TX_DATA(dat[0][DB[0]-1:0]),
        .TX_EN(en[0]), .TX_STATUS(st[0]), .TX_DONE(dn[0]),
        .UART_TX(ln[0]));
    uart_tx_param #(.DATA_BITS(DB[1]), .CLKS_PER_BIT(CB[1]),
                    .PARITY(PB[1]), .STOP_BITS(SB[1])) u1 (
        .sysclk(clk), .reset(rst[1]), .TX_DATA(dat[1][DB[1]-1:0]),
        .TX_EN(en[1]), .TX_STATUS(st[1]), .TX_DONE(dn[1]),
        .UART_TX(ln[1]));
    uart_tx_param #(.DATA_BITS(DB[2]), .CLKS_PER_BIT(CB[2]),
                    .PARITY(PB[2]), .STOP_BITS(SB[2])) u2 (
        .sysclk(clk), .reset(rst[2]), .TX_DATA(dat[2][DB[2]-1:0]),
        .TX_EN(en[2]), .TX_STATUS(st[2]), .TX_DONE(dn[2]),
        .UART_TX(ln[2]));
    uart_tx_param #(.DATA_BITS(DB[3]), .CLKS_PER_BIT(CB[3]),
                    .PARITY(PB[3]), .STOP_BITS(SB[3])) u3 (
        .sysclk(clk), .reset(rst[3]), .TX_DATA(dat[3][DB[3]-1:0]),
        .TX_EN(en[3]), .TX_STATUS(st[3]), .TX_DONE(dn[3]),
        .UART_TX(ln[3]));
    uart_tx_param #(.DATA_BITS(DB[4]), .CLKS_PER_BIT(CB[4]),
                    .PARITY(PB[4]), .STOP_BITS(SB[4])) u4 (
        .sysclk(clk), .reset(rst[4]), .TX_DATA(dat[4][DB[4]-1:0]),
        .TX_EN(en[4]), .TX_STATUS(st[4]), .TX_DONE(dn[4]),
        .UART_TX(ln[4]));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Line bits of one frame, one entry per bit period.
    function automatic bitq_t frame_bits(input int k, input logic [8:0] pl);
        bitq_t q;
        int    ones = 0;
        q.push_back(1'b0);
        for (int j = 0; j < DB[k]; j++) begin
            q.push_back(pl[j]);
            ones += int'(pl[j]);
        end
        if (PB[k] == PAR_EVEN) q.push_back(ones % 2 == 1);
        if (PB[k] == PAR_ODD)  q.push_back(ones % 2 == 0);
        for (int j = 0; j < SB[k]; j++) q.push_back(1'b1);
        return q;
    endfunction

    // pre: request already driven; keep: leave TX_EN high; poke: retry
    // with other data at cycle 5 of the frame.
    task automatic run_frame(input int k, input logic [8:0] pl,
                             input bit pre, input bit keep, input bit poke);
        bitq_t q = frame_bits(k, pl);
        int    n = q.size() * CB[k];
        if (!pre) begin
            @(negedge clk);
            dat[k] = pl;
            en[k]  = 1'b1;
        end
        @(negedge clk);
        if (!keep) en[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("u%0d line c%0d", k, i), 32'(ln[k]),
                  32'(q[i / CB[k]]));
            check($sformatf("u%0d busy c%0d", k, i), 32'(st[k]), 0);
            check($sformatf("u%0d done c%0d", k, i), 32'(dn[k]), 0);
            if (poke && i == 5) begin
                dat[k] = ~pl;
                en[k]  = 1'b1;
            end
            if (poke && i == 6) en[k] = 1'b0;
            @(negedge clk);
        end
        check($sformatf("u%0d end line", k), 32'(ln[k]), 1);
        check($sformatf("u%0d end status", k), 32'(st[k]), 1);
        check($sformatf("u%0d end done", k), 32'(dn[k]), 1);
        if (!keep) begin
            @(negedge clk);
            check($sformatf("u%0d post done", k), 32'(dn[k]), 0);
            check($sformatf("u%0d post status", k), 32'(st[k]), 1);
            check($sformatf("u%0d post line", k), 32'(ln[k]), 1);
        end
    endtask

    task automatic abort_frame(input int k, input logic [8:0] pl,
                               input logic [8:0] pl2);
        @(negedge clk);
        dat[k] = pl;
        en[k]  = 1'b1;
        @(negedge clk);
        en[k] = 1'b0;
        repeat (CB[k] * 3) @(negedge clk);
        check("abort busy before", 32'(st[k]), 0);
        #2 rst[k] = 1'b1;
        #1;
        check("abort line", 32'(ln[k]), 1);
        check("abort status", 32'(st[k]), 1);
        check("abort done", 32'(dn[k]), 0);
        repeat (2) begin
            @(negedge clk);
            check("abort hold done", 32'(dn[k]), 0);
            check("abort hold line", 32'(ln[k]), 1);
        end
        rst[k] = 1'b0;
        @(negedge clk);
        check("abort after done", 32'(dn[k]), 0);
        check("abort after status", 32'(st[k]), 1);
        run_frame(k, pl2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [8:0] pl;
        logic [8:0] pl2;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            en[k]  = 1'b0;
            dat[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d rst line", k), 32'(ln[k]), 1);
            check($sformatf("u%0d rst status", k), 32'(st[k]), 1);
            check($sformatf("u%0d rst done", k), 32'(dn[k]), 0);
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        dat[0] = 9'h0A5;
        en[0]  = 1'b1;
        run_frame(0, 9'h0A5, 1'b1, 1'b0, 1'b0);

        run_frame(1, 9'h007, 1'b0, 1'b0, 1'b0);
        run_frame(2, 9'h007, 1'b0, 1'b0, 1'b0);
        run_frame(3, 9'h07F, 1'b0, 1'b0, 1'b0);

        run_frame(0, 9'h03C, 1'b0, 1'b0, 1'b1);
        run_frame(3, 9'h015, 1'b0, 1'b0, 1'b1);

        run_frame(0, 9'h055, 1'b0, 1'b1, 1'b0);
        dat[0] = 9'h0AA;
        run_frame(0, 9'h0AA, 1'b1, 1'b0, 1'b0);

        abort_frame(0, 9'h096, 9'h03B);

        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 6; r++) begin
                pl = 9'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ($urandom_range(0, 2) == 0) begin
                    run_frame(k, pl, 1'b0, 1'b1, 1'b0);
                    pl2    = 9'($urandom);
                    dat[k] = pl2;
                    run_frame(k, pl2, 1'b1, 1'b0, 1'b0);
                end else begin
                    run_frame(k, pl, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
